// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, ALU operation
// codes, mux-select encodings and the FSM state type.
package mc_pkg;

  localparam int STATE_W = 4;
  // Constant the datapath places on ALU B when ALUSrcB selects the PC increment.
  localparam int PC_INC  = 4;

  // Instruction opcodes (IR[31:28]); 10..15 are illegal.
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;
  localparam logic [3:0] OP_LW   = 4'd4;
  localparam logic [3:0] OP_SW   = 4'd5;
  localparam logic [3:0] OP_BEQ  = 4'd6;
  localparam logic [3:0] OP_BNE  = 4'd7;
  localparam logic [3:0] OP_BLT  = 4'd8;
  localparam logic [3:0] OP_J    = 4'd9;

  // ALU operations; 2'b11 is never driven.
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  // ALU B operand selects.
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_INC    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source selects.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WR = 4'd6,
    S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_FAULT  = 4'd11
  } state_e;

  // ALU operation for the three R-type opcodes; anything else falls back to AND.
  function automatic logic [1:0] r_type_aluop(input logic [3:0] op);
    logic [1:0] aop;
    aop = ALU_AND;
    case (op)
      OP_ADD:  aop = ALU_ADD;
      OP_SUB:  aop = ALU_SUB;
      default: aop = ALU_AND;
    endcase
    return aop;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch resolution from the ALU flags of the compare (SUB) cycle.
// Carry is deliberately not an input: no branch depends on it.
module branch_cond_eval
  import mc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       negative,
  input  logic       overflow,
  output logic       take
);

  // BEQ on equal, BNE on not-equal, BLT on signed less-than (N xor V).
  always_comb begin
    take = 1'b0;
    case (opcode)
      OP_BEQ:  take = zero;
      OP_BNE:  take = ~zero;
      OP_BLT:  take = negative ^ overflow;
      default: take = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control FSM: fetch / decode / execute / memory / writeback.
// Memory handshake: mem_req (with exactly one of MemRead/MemWrite) is raised
// in a memory state and held, unchanged, until the cycle in which mem_ready
// is sampled high; that cycle completes the transfer and the FSM advances.
// Outputs are decoded from the state register; the only input-dependent
// strobes are the fetch completion (IRWrite/PCWrite on mem_ready) and the
// branch PCWrite (on the flag-derived take).
module multicycle_control_unit
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         opcode,
  input  logic               zero,
  input  logic               negative,
  input  logic               carry,
  input  logic               overflow,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic [1:0]         ALUop,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               MemtoReg,
  output logic [3:0]         flags_q,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_flags;
  logic       r_illegal_op;
  logic       w_take;

  branch_cond_eval u_branch_cond_eval (
    .opcode   (opcode),
    .zero     (zero),
    .negative (negative),
    .overflow (overflow),
    .take     (w_take)
  );

  // Next-state selection; memory states wait on mem_ready, FAULT is absorbing.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_AND, OP_ADD, OP_SUB: w_next = S_EXEC_R;
          OP_ADDI:                w_next = S_EXEC_I;
          OP_LW, OP_SW:           w_next = S_ADDR;
          OP_BEQ, OP_BNE, OP_BLT: w_next = S_BRANCH;
          OP_J:                   w_next = S_JUMP;
          default:                w_next = S_FAULT;
        endcase
      end
      S_EXEC_R: w_next = S_WB_ALU;
      S_EXEC_I: w_next = S_WB_ALU;
      S_ADDR:   w_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (mem_ready) w_next = S_WB_MEM;
      S_MEM_WR: if (mem_ready) w_next = S_FETCH;
      S_WB_ALU: w_next = S_FETCH;
      S_WB_MEM: w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FETCH;
    endcase
  end

  // State, R-type flag capture and the sticky illegal-opcode indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_flags      <= 4'b0000;
      r_illegal_op <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXEC_R) begin
        r_flags <= {negative, zero, carry, overflow};
      end
      if (w_next == S_FAULT) begin
        r_illegal_op <= 1'b1;
      end
    end
  end

  // Datapath control decode; everything is held at 0 while reset is asserted
  // so an abandoned instruction can never leave a partial write behind.
  always_comb begin
    mem_req  = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PCSRC_ALU;
    ALUop    = ALU_AND;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_REGB;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          ALUSrcB = SRCB_INC;
          ALUop   = ALU_ADD;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
          PCSrc   = PCSRC_ALU;
        end
        S_DECODE: begin
          ALUSrcB = SRCB_IMM_SH;
          ALUop   = ALU_ADD;
        end
        S_EXEC_R: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REGB;
          ALUop   = r_type_aluop(opcode);
        end
        S_EXEC_I, S_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_IMM;
          ALUop   = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_WB_ALU: begin
          RegWrite = 1'b1;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUSrcB = SRCB_REGB;
          ALUop   = ALU_SUB;
          PCWrite = w_take;
          PCSrc   = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          PCWrite = 1'b1;
          PCSrc   = PCSRC_JUMP;
        end
        default: begin
          // FAULT and unused encodings drive nothing.
        end
      endcase
    end
  end

  assign flags_q    = r_flags;
  assign illegal_op = r_illegal_op;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Each instruction is expanded into a list
// of per-cycle input vectors and expected control words, derived from the
// instruction-class rules (fetch, decode, class-specific steps, memory waits).
module tb_multicycle_control_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] opcode;
  logic       zero, negative, carry, overflow, mem_ready;
  logic       mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0] PCSrc, ALUop, ALUSrcB;
  logic       ALUSrcA, RegWrite, MemtoReg;
  logic [3:0] flags_q;
  logic       illegal_op;
  logic [3:0] state_dbg;

  multicycle_control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .negative   (negative),
    .carry      (carry),
    .overflow   (overflow),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IorD       (IorD),
    .IRWrite    (IRWrite),
    .PCWrite    (PCWrite),
    .PCSrc      (PCSrc),
    .ALUop      (ALUop),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .MemtoReg   (MemtoReg),
    .flags_q    (flags_q),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  // {mem_req,MemRead,MemWrite,IorD,IRWrite,PCWrite,PCSrc,ALUop,ALUSrcA,ALUSrcB,RegWrite,MemtoReg}
  logic [14:0] w_ctl;
  assign w_ctl = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
                  ALUop, ALUSrcA, ALUSrcB, RegWrite, MemtoReg};

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [3:0] op;
    logic       rdy;
    logic [3:0] fl;   // {N,Z,C,V}
    logic       cap;  // flags of this cycle become the architectural flags
  } stim_t;

  stim_t       stim_q[$];
  logic [14:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_flags = 4'b0000;

  function automatic logic [14:0] cw(input logic mreq, input logic mrd, input logic mwr,
                                     input logic iord, input logic irw, input logic pcw,
                                     input logic [1:0] pcsrc, input logic [1:0] aop,
                                     input logic srca, input logic [1:0] srcb,
                                     input logic rw, input logic m2r);
    return {mreq, mrd, mwr, iord, irw, pcw, pcsrc, aop, srca, srcb, rw, m2r};
  endfunction

  function automatic logic [14:0] fetch_word(input logic done);
    return cw(1'b1, 1'b1, 1'b0, 1'b0, done, done, 2'b00, 2'b01, 1'b0, 2'b01, 1'b0, 1'b0);
  endfunction

  // ---------------- driver / model ----------------
  task automatic push(input logic [3:0] op, input logic rdy, input logic [3:0] fl,
                      input logic cap, input logic [14:0] e);
    stim_t s;
    s.op = op; s.rdy = rdy; s.fl = fl; s.cap = cap;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  function automatic logic [3:0] pick_fl(input logic rnd, input logic [3:0] ff);
    return rnd ? 4'($urandom_range(15, 0)) : ff;
  endfunction

  // Expand one instruction: fw fetch wait cycles, mw memory wait cycles.
  task automatic build_instr(input logic [3:0] op, input int fw, input int mw,
                             input logic rnd, input logic [3:0] ff);
    logic [3:0] fl;
    logic       take;
    logic [1:0] aop;
    logic       any_rdy;
    for (int i = 0; i < fw; i++) push(op, 1'b0, pick_fl(rnd, ff), 1'b0, fetch_word(1'b0));
    push(op, 1'b1, pick_fl(rnd, ff), 1'b0, fetch_word(1'b1));
    any_rdy = 1'($urandom_range(1, 0));
    push(op, any_rdy, pick_fl(rnd, ff), 1'b0,
         cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 2'b11, 1'b0, 1'b0));
    if (op <= 4'd2) begin
      aop = (op == 4'd0) ? 2'b00 : (op == 4'd1) ? 2'b01 : 2'b10;
      push(op, 1'($urandom_range(1, 0)), pick_fl(rnd, ff), 1'b1,
           cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, aop, 1'b1, 2'b00, 1'b0, 1'b0));
      push(op, 1'($urandom_range(1, 0)), pick_fl(rnd, ff), 1'b0,
           cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0));
    end else if (op == 4'd3 || op == 4'd4 || op == 4'd5) begin
      push(op, 1'($urandom_range(1, 0)), pick_fl(rnd, ff), 1'b0,
           cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0));
      if (op == 4'd3) begin
        push(op, 1'($urandom_range(1, 0)), pick_fl(rnd, ff), 1'b0,
             cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0));
      end else begin
        for (int i = 0; i <= mw; i++)
          push(op, (i == mw), pick_fl(rnd, ff), 1'b0,
               cw(1'b1, (op == 4'd4), (op == 4'd5), 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0,
                  2'b00, 1'b0, 1'b0));
        if (op == 4'd4)
          push(op, 1'($urandom_range(1, 0)), pick_fl(rnd, ff), 1'b0,
               cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1));
      end
    end else if (op >= 4'd6 && op <= 4'd8) begin
      fl = pick_fl(rnd, ff);
      take = (op == 4'd6) ? fl[2] : (op == 4'd7) ? ~fl[2] : (fl[3] ^ fl[0]);
      push(op, 1'($urandom_range(1, 0)), fl, 1'b0,
           cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, take, 2'b01, 2'b10, 1'b1, 2'b00, 1'b0, 1'b0));
    end else if (op == 4'd9) begin
      push(op, 1'($urandom_range(1, 0)), pick_fl(rnd, ff), 1'b0,
           cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
    end
  endtask

  task automatic run_queue(input string name);
    while (stim_q.size() > 0) begin
      stim_t       s;
      logic [14:0] e;
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      opcode = s.op;
      mem_ready = s.rdy;
      {negative, zero, carry, overflow} = s.fl;
      #1;
      checks++;
      if (w_ctl !== e) begin
        errors++;
        $display("FAIL %s ctl op=%0d state=%0d got=%b exp=%b", name, s.op, state_dbg, w_ctl, e);
      end
      checks++;
      if (flags_q !== exp_flags) begin
        errors++;
        $display("FAIL %s flags_q got=%b exp=%b", name, flags_q, exp_flags);
      end
      checks++;
      if (illegal_op !== 1'b0) begin
        errors++;
        $display("FAIL %s illegal_op got=%b exp=0", name, illegal_op);
      end
      if (s.cap) exp_flags = s.fl;
    end
  endtask

  // Assert reset at a negedge, hold two cycles, release with mem_ready low.
  task automatic reset_pulse(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'($urandom_range(1, 0));
    #1;
    exp_flags = 4'b0000;
    checks++;
    if (w_ctl !== 15'd0) begin
      errors++;
      $display("FAIL %s strobes_in_reset got=%b exp=0", name, w_ctl);
    end
    checks++;
    if (flags_q !== 4'b0000 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL %s regs_in_reset flags=%b illegal=%b exp 0000/0", name, flags_q, illegal_op);
    end
    repeat (2) @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (w_ctl !== fetch_word(1'b0)) begin
      errors++;
      $display("FAIL %s fetch_after_release got=%b exp=%b", name, w_ctl, fetch_word(1'b0));
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (w_ctl !== 15'd0 || flags_q !== 4'b0000 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial ctl=%b flags=%b illegal=%b exp all 0", w_ctl, flags_q, illegal_op);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (w_ctl !== fetch_word(1'b0)) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", w_ctl, fetch_word(1'b0));
    end
    // Two fetch wait cycles, then reset lands mid-FETCH.
    push(4'd1, 1'b0, 4'h0, 1'b0, fetch_word(1'b0));
    push(4'd1, 1'b0, 4'h0, 1'b0, fetch_word(1'b0));
    run_queue("reset_fetch_wait");
    reset_pulse("reset_mid_fetch");
    // ADD abandoned in EXEC_R: its flags must never be captured.
    build_instr(4'd1, 0, 0, 1'b0, 4'hF);
    void'(stim_q.pop_back()); void'(exp_q.pop_back());
    void'(stim_q.pop_back()); void'(exp_q.pop_back());
    run_queue("reset_abandon_prefix");
    reset_pulse("reset_mid_exec");
  endtask

  task automatic test_add();
    build_instr(4'd1, 0, 0, 1'b0, 4'b0010);
    run_queue("add_carry");
    checks++;
    if (flags_q !== 4'b0010) begin
      errors++;
      $display("FAIL add_flags got=%b exp=0010", flags_q);
    end
    build_instr(4'd2, 1, 0, 1'b0, 4'b1101);
    build_instr(4'd0, 0, 0, 1'b1, 4'h0);
    build_instr(4'd3, 2, 0, 1'b0, 4'b0110);
    run_queue("r_type_back_to_back");
  endtask

  task automatic test_lw_wait();
    build_instr(4'd4, 0, 3, 1'b1, 4'h0);
    build_instr(4'd4, 2, 0, 1'b1, 4'h0);
    run_queue("lw_wait");
  endtask

  task automatic test_branch();
    build_instr(4'd6, 0, 0, 1'b0, 4'b0100);  // BEQ taken
    build_instr(4'd6, 0, 0, 1'b0, 4'b0000);  // BEQ not taken
    build_instr(4'd8, 0, 0, 1'b0, 4'b1001);  // BLT N=V -> not taken
    build_instr(4'd8, 1, 0, 1'b0, 4'b1010);  // BLT N^V -> taken, carry ignored
    build_instr(4'd7, 0, 0, 1'b0, 4'b0100);  // BNE not taken
    build_instr(4'd9, 0, 0, 1'b1, 4'h0);     // J
    run_queue("branch");
  endtask

  task automatic test_sw();
    build_instr(4'd5, 0, 0, 1'b1, 4'h0);
    build_instr(4'd5, 1, 2, 1'b1, 4'h0);
    run_queue("sw");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      build_instr(4'($urandom_range(9, 0)), int'($urandom_range(2, 0)),
                  int'($urandom_range(2, 0)), 1'b1, 4'h0);
    run_queue("random");
  endtask

  task automatic test_fault();
    build_instr(4'hC, 0, 0, 1'b1, 4'h0);  // fetch + decode only
    run_queue("fault_entry");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(1, 0));
      opcode = 4'($urandom_range(15, 0));
      {negative, zero, carry, overflow} = 4'($urandom_range(15, 0));
      #1;
      checks++;
      if (w_ctl !== 15'd0 || illegal_op !== 1'b1 || flags_q !== exp_flags) begin
        errors++;
        $display("FAIL fault_hold cyc=%0d ctl=%b illegal=%b flags=%b exp 0/1/%b",
                 i, w_ctl, illegal_op, flags_q, exp_flags);
      end
    end
    reset_pulse("fault_clear");
    build_instr(4'd1, 0, 0, 1'b1, 4'h0);
    run_queue("after_fault");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst_n = 1'b0;
    opcode = 4'd0;
    zero = 1'b0; negative = 1'b0; carry = 1'b0; overflow = 1'b0;
    mem_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_sw();
    test_random();
    test_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
